// File: rtl/data_mem_access_ctrl.sv
// Load/store sequencer for a word-wide data memory: sub-word stores by
// read-modify-write, sign/zero-extended loads, and fault screening up front.
module data_mem_access_ctrl #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state, state_nxt;
  logic        write_p0;
  logic [1:0]  size_p0;
  logic        uns_p0;
  logic [1:0]  lane_p0;
  logic [31:0] wdata_p0;
  logic        fault_p0;
  logic [31:0] word_p1;
  logic        req_fault;
  logic        word_store;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sx;
    logic [31:0]        r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h  = lane[1] ? word[31:16] : word[15:0];
    sx = '0;
    r  = word;
    if (size == 2'b00) begin
      sx = b;
      r  = uns ? {24'h0, b} : sx;
    end else if (size == 2'b01) begin
      sx = h;
      r  = uns ? {16'h0, h} : sx;
    end
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    if (size == 2'b00) begin
      case (lane)
        2'd0:    r[7:0]   = wdata[7:0];
        2'd1:    r[15:8]  = wdata[7:0];
        2'd2:    r[23:16] = wdata[7:0];
        default: r[31:24] = wdata[7:0];
      endcase
    end else if (size == 2'b01) begin
      if (lane[1]) r[31:16] = wdata[15:0];
      else         r[15:0]  = wdata[15:0];
    end else begin
      r = wdata;
    end
    return r;
  endfunction

  always_comb begin
    req_fault = 1'b0;
    case (req_size)
      2'b01:   req_fault = req_addr[0];
      2'b10:   req_fault = (req_addr[1:0] != 2'b00);
      2'b11:   req_fault = 1'b1;
      default: req_fault = 1'b0;
    endcase
    if ({2'b00, req_addr[31:2]} >= DEPTH_W) req_fault = 1'b1;
  end

  assign word_store = write_p0 && (size_p0 == 2'b10);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_fault ? RESP : ACCESS;
      ACCESS:  state_nxt = (!write_p0 || word_store) ? RESP : WRITE;
      WRITE:   state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: request latched at acceptance; p1: memory word captured in ACCESS
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_p0 <= 1'b0;
      size_p0  <= 2'b00;
      uns_p0   <= 1'b0;
      lane_p0  <= 2'b00;
      wdata_p0 <= '0;
      fault_p0 <= 1'b0;
      mem_addr <= '0;
      word_p1  <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        write_p0 <= req_write;
        size_p0  <= req_size;
        uns_p0   <= req_unsigned;
        lane_p0  <= req_addr[1:0];
        wdata_p0 <= req_wdata;
        fault_p0 <= req_fault;
        // A faulting request leaves the memory address untouched.
        if (!req_fault) mem_addr <= {2'b00, req_addr[31:2]};
      end
      if (state == ACCESS) word_p1 <= mem_read_data;
    end
  end

  always_comb begin
    req_ready        = (state == IDLE);
    resp_valid       = (state == RESP);
    resp_fault       = (state == RESP) && fault_p0;
    resp_rdata       = '0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    case (state)
      ACCESS: if (word_store) begin
        mem_write_enable = 1'b1;
        mem_write_data   = wdata_p0;
      end
      WRITE: begin
        mem_write_enable = 1'b1;
        mem_write_data   = store_merge(word_p1, wdata_p0, size_p0, lane_p0);
      end
      RESP: if (!write_p0 && !fault_p0) resp_rdata = load_extend(word_p1, size_p0, lane_p0, uns_p0);
      default: ;
    endcase
  end

endmodule

// File: doc/data_mem_access_ctrl.md
Name: data_mem_access_ctrl

Overview:
Sequencer between the core's load/store stage and the word-wide data_memory32 (combinational read, synchronous write on write_enable).
- Converts byte, halfword and word requests into word accesses.
- Uses read-modify-write for sub-word stores.
- Sign- or zero-extends loads.
- Flags misaligned, illegal-size and out-of-range accesses as faults, without touching memory.

Parameters:
DEPTH, 1024, number of 32-bit words in the attached memory; word index >= DEPTH is out of range.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  extended load data; 0 for stores and faults
resp_fault  output  1  valid with resp_valid; request rejected
mem_addr  output  32  word index to memory (req_addr >> 2)
mem_write_enable  output  1  memory write strobe
mem_write_data  output  32  full word to write
mem_read_data  input  32  memory combinational read data

Behaviour:
- States: IDLE, ACCESS, WRITE, RESP. Reset (async) forces the following:
  - State goes to IDLE.
  - req_ready=1; resp_valid=0, resp_rdata=0, resp_fault=0.
  - mem_write_enable=0, mem_addr=0, mem_write_data=0.
  - All latched request registers are cleared.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write, size, unsigned, addr and wdata.
  - Compute fault: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr>>2 >= DEPTH.
  - Fault -> RESP with fault=1, no memory activity. Otherwise -> ACCESS.
- ACCESS:
  - mem_addr = latched addr>>2; mem_read_data is captured into an internal word register at the cycle end.
  - Load -> RESP.
  - Word store: mem_write_enable=1 and mem_write_data=wdata in this cycle, then -> RESP.
  - Byte or half store -> WRITE.
- WRITE: mem_write_enable=1 and mem_write_data = captured word with the addressed lane(s) replaced. Lanes are little-endian:
  - Byte goes to lane addr[1:0].
  - Half goes to bits [15:0] when addr[1]=0, or [31:16] when addr[1]=1.
  - Then -> RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0.
  - resp_rdata: for loads, the selected lane(s) extended per unsigned flag; for a word load, the word unchanged. 0 for stores and faults.
  - Then -> IDLE.
- req_ready is 0 in ACCESS, WRITE and RESP; req_valid in those states is ignored.
- A new request is accepted the cycle after RESP. No back-to-back overlap.
- Latency, counted from the acceptance cycle (req_valid & req_ready in IDLE):
  - Fault: resp_valid in the next cycle.
  - Load or word store: resp_valid 2 cycles later.
  - Byte or half store: resp_valid 3 cycles later.
- mem_write_enable is high for exactly one cycle per non-faulting store and never for loads or faults.
- mem_addr holds its last value outside ACCESS and WRITE.
- Reset asserted mid-operation:
  - The operation is aborted and no response is issued.
  - A write whose enable cycle has not reached a clock edge is not committed.
- req_wdata bits above the access size are ignored.
- Address bits [31:2] beyond DEPTH fault; no wrap-around.

Test Plan:
- Reset, then word store addr 0x10 data 0xDEADBEEF, then word load addr 0x10:
  - Store: one write cycle with mem_addr=4; resp_valid 2 cycles after acceptance.
  - Load: resp_rdata=0xDEADBEEF, fault=0.
- Memory word 4 = 0x11223344:
  - Byte store 0xAA at addr 0x12 writes 0x11AA3344 (resp 3 cycles after accept).
  - Half store 0xBEEF at 0x10 then gives 0x11AABEEF.
- Word 4 = 0x8077F0FF:
  - Signed byte load 0x10 -> 0xFFFFFFFF; unsigned byte 0x11 -> 0x000000F0.
  - Signed half 0x12 -> 0xFFFF8077; unsigned half 0x12 -> 0x00008077.
- Faults, each with resp_fault=1 and resp_valid 1 cycle after accept, resp_rdata=0, mem_write_enable never high, memory unchanged:
  - Half store at 0x13.
  - Word load at 0x0E.
  - size=11.
  - Word load at 0x1000 (index 1024, DEPTH=1024).
- Hold req_valid high continuously with two different requests:
  - req_ready drops in ACCESS/WRITE/RESP.
  - The second request is accepted only after resp_valid; exactly two resp_valid pulses result.
- Assert reset during the WRITE state of a byte store:
  - All outputs return to reset values immediately; no resp_valid.
  - Memory word retains its pre-store value (0x11223344).
  - The next load works normally.
